// File: rtl/sb_msg_arbiter_if.sv
// Sideband message arbiter bus: requester side plus SB encoder handshake.
// master = the environment driving requests and encoder status,
// slave  = the arbiter itself.
interface sb_msg_arbiter_if #(
    parameter int SB_MSG_WIDTH = 4,
    parameter int NUM_REQ      = 2
);
    logic                            i_en;
    logic [NUM_REQ-1:0]              i_req_valid;
    logic [NUM_REQ*SB_MSG_WIDTH-1:0] i_req_msg;
    logic                            i_sb_busy;
    logic [SB_MSG_WIDTH-1:0]         o_sb_msg;
    logic                            o_sb_valid;
    logic [NUM_REQ-1:0]              o_grant;
    logic [NUM_REQ-1:0]              o_done;
    logic                            o_timeout_err;

    modport master (
        output i_en, i_req_valid, i_req_msg, i_sb_busy,
        input  o_sb_msg, o_sb_valid, o_grant, o_done, o_timeout_err
    );

    modport slave (
        input  i_en, i_req_valid, i_req_msg, i_sb_busy,
        output o_sb_msg, o_sb_valid, o_grant, o_done, o_timeout_err
    );
endinterface

// File: rtl/sb_msg_arbiter.sv
// Round-robin arbiter sharing one sideband message encoder between the
// link-training TX/RX sub-FSMs. Latches the winner's message, runs one
// valid/busy handshake with a watchdog, and pulses done to the winner.
module sb_msg_arbiter #(
    parameter int SB_MSG_WIDTH = 4,
    parameter int NUM_REQ      = 2,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    sb_msg_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_FALL} state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d, own_q, own_d, own_nxt, win;
    logic [7:0]              wdog_q, wdog_d;
    logic [8:0]              wdog_inc;
    logic [NUM_REQ-1:0]      mask_q, mask_d, grant_q, grant_d, done_q, done_d, elig;
    logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
    logic                    valid_q, valid_d, tmo_q, tmo_d, busy_q, busy_fall, found;
    int                      idx;

    assign busy_fall = busy_q & ~bus.i_sb_busy;
    assign wdog_inc  = {1'b0, wdog_q} + 9'd1;
    assign own_nxt   = (own_q == PTR_W'(NUM_REQ - 1)) ? '0 : own_q + PTR_W'(1);

    assign bus.o_sb_msg      = msg_q;
    assign bus.o_sb_valid    = valid_q;
    assign bus.o_grant       = grant_q;
    assign bus.o_done        = done_q;
    assign bus.o_timeout_err = tmo_q;

    // First eligible requester at or after the RR pointer, wrapping around.
    always_comb begin
        elig  = bus.i_req_valid & ~mask_q;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    // Next-state and next-output logic; i_en low flushes everything to IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        wdog_d  = wdog_q;
        mask_d  = '0;
        grant_d = grant_q;
        done_d  = '0;
        msg_d   = msg_q;
        valid_d = valid_q;
        tmo_d   = 1'b0;
        if (!bus.i_en) begin
            state_d = IDLE;
            ptr_d   = '0;
            own_d   = '0;
            wdog_d  = '0;
            grant_d = '0;
            msg_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Foreign traffic on the encoder holds off any grant.
                    if (!bus.i_sb_busy && found) begin
                        state_d      = SEND;
                        own_d        = win;
                        grant_d      = '0;
                        grant_d[win] = 1'b1;
                        msg_d        = bus.i_req_msg[int'(win)*SB_MSG_WIDTH +: SB_MSG_WIDTH];
                        valid_d      = 1'b1;
                        wdog_d       = '0;
                    end
                end
                SEND: begin
                    if (bus.i_sb_busy) begin
                        state_d = WAIT_FALL;
                        wdog_d  = '0;
                    end else if (wdog_inc >= 9'(TIMEOUT_CYC)) begin
                        // Encoder never accepted: abort without done, still rotate.
                        state_d = IDLE;
                        valid_d = 1'b0;
                        grant_d = '0;
                        tmo_d   = 1'b1;
                        ptr_d   = own_nxt;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = (wdog_q == 8'hFF) ? wdog_q : wdog_inc[7:0];
                    end
                end
                WAIT_FALL: begin
                    if (busy_fall) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        grant_d = '0;
                        done_d  = grant_q;
                        // One-cycle mask covers the cycle the owner drops its valid.
                        mask_d  = grant_q;
                        ptr_d   = own_nxt;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            wdog_q  <= '0;
            mask_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            msg_q   <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            wdog_q  <= wdog_d;
            mask_q  <= mask_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    // Registered encoder busy for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) busy_q <= 1'b0;
        else          busy_q <= bus.i_sb_busy;
    end
endmodule

// File: tb/tb_sb_msg_arbiter.sv
// Directed bench for sb_msg_arbiter. Observed word layout:
// {valid, grant[1:0], done[1:0], timeout_err, msg[3:0]}.
module tb_sb_msg_arbiter;
    localparam int W   = 4;
    localparam int N   = 2;
    localparam int TMO = 8;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    sb_msg_arbiter_if #(.SB_MSG_WIDTH(W), .NUM_REQ(N)) bus ();

    sb_msg_arbiter #(.SB_MSG_WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    function automatic logic [9:0] obs();
        return {bus.o_sb_valid, bus.o_grant, bus.o_done, bus.o_timeout_err, bus.o_sb_msg};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic flush();
        bus.i_en = 1'b0;
        tick();
        bus.i_en = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        i_rst_n = 1'b0;
        bus.i_en = 1'b0; bus.i_req_valid = '0; bus.i_req_msg = '0; bus.i_sb_busy = 1'b0;
        tick(); tick();
        e = '0;
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL reset_outputs got=%h exp=%h", obs(), e); end
        #3 i_rst_n = 1'b1;
        bus.i_en = 1'b1;
        tick();
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL reset_idle got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_single();
        logic [9:0] e;
        flush();
        bus.i_req_valid = 2'b01; bus.i_req_msg = {4'h0, 4'h1};
        tick();
        e = {1'b1, 2'b01, 2'b00, 1'b0, 4'h1};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL single_grant got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b00; bus.i_req_msg = {4'h0, 4'hF};
        bus.i_sb_busy = 1'b1;
        tick();
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL single_hold got=%h exp=%h", obs(), e); end
        tick(); tick();
        bus.i_sb_busy = 1'b0;
        tick();
        e = {1'b0, 2'b00, 2'b01, 1'b0, 4'h1};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL single_done got=%h exp=%h", obs(), e); end
        tick();
        e = {1'b0, 2'b00, 2'b00, 1'b0, 4'h1};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL single_done_pulse got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_collision();
        logic [9:0] e;
        flush();
        bus.i_req_valid = 2'b11; bus.i_req_msg = {4'h2, 4'h1};
        tick();
        e = {1'b1, 2'b01, 2'b00, 1'b0, 4'h1};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL coll_grant0 got=%h exp=%h", obs(), e); end
        bus.i_sb_busy = 1'b1; tick(); bus.i_sb_busy = 1'b0; tick();
        e = {1'b0, 2'b00, 2'b01, 1'b0, 4'h1};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL coll_done0 got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b10;
        tick();
        e = {1'b1, 2'b10, 2'b00, 1'b0, 4'h2};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL coll_grant1 got=%h exp=%h", obs(), e); end
        bus.i_sb_busy = 1'b1; tick(); bus.i_sb_busy = 1'b0; tick();
        e = {1'b0, 2'b00, 2'b10, 1'b0, 4'h2};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL coll_done1 got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b00;
        tick();
        bus.i_req_valid = 2'b11; bus.i_req_msg = {4'h7, 4'h6};
        tick();
        e = {1'b1, 2'b01, 2'b00, 1'b0, 4'h6};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL coll_rr got=%h exp=%h", obs(), e); end
        bus.i_sb_busy = 1'b1; tick(); bus.i_sb_busy = 1'b0; tick();
        bus.i_req_valid = 2'b00;
        tick();
    endtask

    task automatic test_sticky();
        logic [9:0] e;
        flush();
        bus.i_req_valid = 2'b01; bus.i_req_msg = {4'h4, 4'h3};
        tick();
        bus.i_sb_busy = 1'b1; tick(); bus.i_sb_busy = 1'b0; tick();
        e = {1'b0, 2'b00, 2'b01, 1'b0, 4'h3};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL sticky_done got=%h exp=%h", obs(), e); end
        tick();
        e = {1'b0, 2'b00, 2'b00, 1'b0, 4'h3};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL sticky_mask got=%h exp=%h", obs(), e); end
        tick();
        e = {1'b1, 2'b01, 2'b00, 1'b0, 4'h3};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL sticky_regrant got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b11;
        bus.i_sb_busy = 1'b1; tick(); bus.i_sb_busy = 1'b0; tick();
        tick();
        e = {1'b1, 2'b10, 2'b00, 1'b0, 4'h4};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL sticky_rr got=%h exp=%h", obs(), e); end
        bus.i_sb_busy = 1'b1; tick(); bus.i_sb_busy = 1'b0; tick();
        bus.i_req_valid = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        flush();
        bus.i_req_valid = 2'b01; bus.i_req_msg = {4'h0, 4'h5};
        tick();
        e = {1'b1, 2'b01, 2'b00, 1'b0, 4'h5};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL tmo_grant got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b00;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL tmo_hold[%0d] got=%h exp=%h", i, obs(), e); end
        end
        tick();
        e = {1'b0, 2'b00, 2'b00, 1'b1, 4'h5};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL tmo_abort got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b11; bus.i_req_msg = {4'h9, 4'h8};
        tick();
        e = {1'b1, 2'b10, 2'b00, 1'b0, 4'h9};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL tmo_ptr_adv got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b00;
    endtask

    task automatic test_flush();
        logic [9:0] e;
        flush();
        bus.i_req_valid = 2'b01; bus.i_req_msg = {4'h7, 4'h6};
        tick();
        bus.i_req_valid = 2'b00;
        bus.i_sb_busy = 1'b1; tick(); bus.i_sb_busy = 1'b0; tick();
        bus.i_req_valid = 2'b10;
        tick();
        e = {1'b1, 2'b10, 2'b00, 1'b0, 4'h7};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL flush_setup got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b00;
        bus.i_sb_busy = 1'b1; tick();
        bus.i_en = 1'b0;
        tick();
        e = '0;
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL flush_outputs got=%h exp=%h", obs(), e); end
        bus.i_en = 1'b1; bus.i_sb_busy = 1'b0;
        tick();
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL flush_no_done got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b11; bus.i_req_msg = {4'h9, 4'h8};
        tick();
        e = {1'b1, 2'b01, 2'b00, 1'b0, 4'h8};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL flush_ptr0 got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b00;
        bus.i_sb_busy = 1'b1; tick(); bus.i_sb_busy = 1'b0; tick();
    endtask

    task automatic test_busy_at_req();
        logic [9:0] e;
        flush();
        bus.i_sb_busy = 1'b1;
        bus.i_req_valid = 2'b10; bus.i_req_msg = {4'h3, 4'h0};
        e = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL busyreq_hold[%0d] got=%h exp=%h", i, obs(), e); end
        end
        bus.i_sb_busy = 1'b0;
        tick();
        e = {1'b1, 2'b10, 2'b00, 1'b0, 4'h3};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL busyreq_grant got=%h exp=%h", obs(), e); end
        bus.i_req_valid = 2'b00;
        bus.i_sb_busy = 1'b1; tick(); bus.i_sb_busy = 1'b0; tick();
        e = {1'b0, 2'b00, 2'b10, 1'b0, 4'h3};
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL busyreq_done got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_async_reset();
        logic [9:0] e;
        flush();
        bus.i_req_valid = 2'b01; bus.i_req_msg = {4'h0, 4'hA};
        tick();
        bus.i_req_valid = 2'b00;
        bus.i_sb_busy = 1'b1;
        tick();
        #2 i_rst_n = 1'b0;
        #1;
        e = '0;
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL async_reset got=%h exp=%h", obs(), e); end
        bus.i_sb_busy = 1'b0;
        #3 i_rst_n = 1'b1;
        tick();
        vec_cnt++; if (obs() !== e) begin err_cnt++; $display("FAIL async_reset_release got=%h exp=%h", obs(), e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_sticky();
        test_timeout();
        test_flush();
        test_busy_at_req();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
